// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC returning atan2(y, x) in Q3.6
// and the gain-compensated magnitude in Q1.7, one vector at a time.
module cordic_vectoring #(
   parameter int ITER = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] angle,
   output logic [7:0] magnitude
);
   typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;
   localparam logic signed [10:0] T [8] = '{11'sd201, 11'sd119, 11'sd63, 11'sd32,
                                            11'sd16, 11'sd8, 11'sd4, 11'sd2};
   state_t state, state_nx;
   logic signed [11:0] x_r, y_r, x_nx, y_nx, xs, ys, xe, ye, mq;
   logic signed [10:0] z_r, z_nx, t;
   logic [2:0] i_r, i_nx;
   logic zero_r, zero_nx, neg;
   logic [8:0] angle_nx;
   logic [7:0] mag_nx;
   assign xe = signed'({{2{x_in[7]}}, x_in, 2'b00});
   assign ye = signed'({{2{y_in[7]}}, y_in, 2'b00});
   assign xs = x_r >>> i_r;
   assign ys = y_r >>> i_r;
   assign t = T[i_r];
   assign neg = y_r[11];
   // X*155/1024 folds the 1/K gain and the Q3.9 -> Q1.7 rescale into one step
   assign mq = 12'((x_r * 22'sd155 + 22'sd512) >>> 10);
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   always_comb begin
      state_nx = state;
      x_nx = x_r;
      y_nx = y_r;
      z_nx = z_r;
      i_nx = i_r;
      zero_nx = zero_r;
      angle_nx = angle;
      mag_nx = magnitude;
      unique case (state)
         IDLE: if (in_valid) begin
            x_nx = !x_in[7] ? xe : (!y_in[7] ? ye : -ye);
            y_nx = !x_in[7] ? ye : (!y_in[7] ? -xe : xe);
            z_nx = !x_in[7] ? 11'sd0 : (!y_in[7] ? 11'sd402 : -11'sd402);
            i_nx = 3'd0;
            zero_nx = x_in == 8'd0 && y_in == 8'd0;
            state_nx = ROTATE;
         end
         ROTATE: begin
            x_nx = neg ? x_r - ys : x_r + ys;
            y_nx = neg ? y_r + xs : y_r - xs;
            z_nx = neg ? z_r - t : z_r + t;
            i_nx = i_r + 3'd1;
            state_nx = i_r == 3'(ITER - 1) ? SCALE : ROTATE;
         end
         SCALE: begin
            angle_nx = zero_r ? 9'd0 : 9'((z_r + 11'sd2) >>> 2);
            mag_nx = zero_r || mq[11] ? 8'd0 : (|mq[10:8] ? 8'hFF : mq[7:0]);
            state_nx = DONE;
         end
         DONE: state_nx = out_ready ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         x_r <= '0;
         y_r <= '0;
         z_r <= '0;
         i_r <= '0;
         zero_r <= 1'b0;
         angle <= '0;
         magnitude <= '0;
      end else begin
         state <= state_nx;
         x_r <= x_nx;
         y_r <= y_nx;
         z_r <= z_nx;
         i_r <= i_nx;
         zero_r <= zero_nx;
         angle <= angle_nx;
         magnitude <= mag_nx;
      end
endmodule
